edge_detect_multi: RTL and testbench

Parametrised, multi-channel successor to the single-bit edge detector.

---
 rtl/edge_pkg.sv | 16 +
 rtl/edge_filter_ch.sv | 70 +++++++
 rtl/edge_detect_multi.sv | 79 +++++++
 tb/tb_edge_detect_multi.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
//   EDGE_* : per-channel edge-mode encodings (bit 0 = rise enable, bit 1 = fall enable)
//   cnt_width() : width of the per-channel filter counter
package edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // At least one bit so FILT_CYCLES == 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel of the edge detector: synchroniser chain, debounce filter, filtered level and
// registered one-cycle rise/fall pulses.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   sig   : raw (possibly asynchronous) input
//   level : filtered, debounced level
//   rise  : one-cycle pulse when level goes 0->1
//   fall  : one-cycle pulse when level goes 1->0
module edge_filter_ch
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(FILT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d;

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // A return of sync_q to the current level drops all accumulated credit.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q == level) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync_q;
      cnt_d   = '0;
      rise_d  = sync_q;
      fall_d  = ~sync_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain_q <= '0;
      cnt_q        <= '0;
      level        <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
    end else begin
      sync_chain_q[0] <= sig;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain_q[i] <= sync_chain_q[i-1];
      end
      cnt_q <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronising, debouncing edge detector with sticky pending flags and a
// combined interrupt.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   sig   : raw input levels [CH]
//   mode  : per-channel edge mode [2*CH]; bits [2i+1:2i] for channel i
//   clr   : per-channel pending clear pulse [CH]
//   level : filtered levels [CH]
//   rise  : rise pulses [CH]
//   fall  : fall pulses [CH]
//   pend  : sticky pending flags [CH]
//   irq   : OR of pending flags, registered alongside pend
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   sig,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic [CH-1:0]   pend,
  output logic            irq
);

  logic [CH-1:0] ev;
  logic [CH-1:0] pend_q, pend_d;
  logic          irq_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .sig  (sig[g]),
      .level(level[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  always_comb begin
    ev = '0;
    for (int i = 0; i < CH; i++) begin
      unique case (mode[2*i +: 2])
        EDGE_OFF:  ev[i] = 1'b0;
        EDGE_RISE: ev[i] = rise[i];
        EDGE_FALL: ev[i] = fall[i];
        EDGE_BOTH: ev[i] = rise[i] | fall[i];
        default:   ev[i] = 1'b0;
      endcase
    end
  end

  // Set has priority over clear so an event coinciding with a clear is not lost.
  assign pend_d = (pend_q & ~clr) | ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign pend = pend_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   sig;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level, rise, fall, pend;
  logic            irq;

  int checks = 0;
  int errors = 0;

  // Reference model: history of sampled inputs; a channel's level flips when the last FC
  // synchronised samples all disagree with it.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_rise, m_fall, m_pend;
  logic          m_irq;

  edge_detect_multi #(
    .CH(CH),
    .SYNC_STAGES(SS),
    .FILT_CYCLES(FC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sig  (sig),
    .mode (mode),
    .clr  (clr),
    .level(level),
    .rise (rise),
    .fall (fall),
    .pend (pend),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    logic [CH-1:0] ev, nl;
    bit all_diff;
    if (rst) begin
      hist = {};
      for (int i = 0; i < SS + FC; i++) hist.push_back('0);
      m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
      return;
    end
    for (int i = 0; i < CH; i++)
      ev[i] = (m_rise[i] & mode[2*i]) | (m_fall[i] & mode[2*i+1]);
    hist.push_back(sig);
    void'(hist.pop_front());
    nl = m_level;
    for (int i = 0; i < CH; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < FC; j++)
        if (hist[hist.size()-1-SS-j][i] == m_level[i]) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_level[i];
    end
    m_rise  = nl & ~m_level;
    m_fall  = ~nl & m_level;
    m_level = nl;
    m_pend  = (m_pend & ~clr) | ev;
    m_irq   = |m_pend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sig = '1; mode = '0; clr = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({level, rise, fall, pend, irq} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got %b exp 0", {level, rise, fall, pend, irq});
      end
    end
    sig = '0; rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (level !== 4'b0000) begin
      errors++;
      $display("FAIL reset_settle_level got %b exp 0000", level);
    end
  endtask

  task automatic test_basic_rise();
    sig[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (fall[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_no_fall cyc %0d got %b exp 0", k, fall[0]);
      end
      checks++;
      if ({level[0], rise[0]} !== ((k < 5) ? 2'b00 : (k == 5) ? 2'b11 : 2'b10)) begin
        errors++;
        $display("FAIL basic_rise cyc %0d got lvl/rise %b%b", k, level[0], rise[0]);
      end
    end
  endtask

  task automatic test_glitch();
    sig[1] = 1'b1; tick(); tick();
    sig[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({level[1], rise[1], fall[1]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch_reject cyc %0d got %b exp 000", k, {level[1], rise[1], fall[1]});
      end
    end
    sig[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (rise[1] !== (k == 5)) begin
        errors++;
        $display("FAIL glitch_hold_rise cyc %0d got %b exp %b", k, rise[1], k == 5);
      end
    end
  endtask

  task automatic test_mode_pend();
    logic prev_rise;
    sig = '0;
    for (int k = 0; k < 8; k++) tick();
    clr = '1; tick(); clr = '0;
    mode = 8'b0000_0001;
    sig[0] = 1'b1;
    prev_rise = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c == 10) sig[0] = 1'b0;
      tick();
      if (prev_rise) begin
        checks++;
        if ({pend[0], irq} !== 2'b11) begin
          errors++;
          $display("FAIL mode_pend_set got pend/irq %b%b exp 11", pend[0], irq);
        end
      end
      prev_rise = rise[0];
    end
    checks++;
    if ({pend, irq} !== 5'b0001_1) begin
      errors++;
      $display("FAIL mode_pend_after_fall got %b exp 00011", {pend, irq});
    end
    clr[0] = 1'b1; tick(); clr = '0;
    checks++;
    if ({pend, irq} !== 5'b0000_0) begin
      errors++;
      $display("FAIL mode_pend_clear got %b exp 00000", {pend, irq});
    end
  endtask

  task automatic test_collision();
    int n;
    mode = 8'b0011_0001;
    sig[2] = 1'b1;
    n = 0;
    while (rise[2] !== 1'b1 && n < 12) begin tick(); n++; end
    tick();
    checks++;
    if (pend[2] !== 1'b1) begin
      errors++;
      $display("FAIL collision_first_set got %b exp 1", pend[2]);
    end
    sig[2] = 1'b0;
    n = 0;
    while (fall[2] !== 1'b1 && n < 12) begin tick(); n++; end
    checks++;
    if (fall[2] !== 1'b1) begin
      errors++;
      $display("FAIL collision_fall_timeout got %b exp 1", fall[2]);
    end
    clr[2] = 1'b1; tick(); clr = '0;
    checks++;
    if (pend[2] !== 1'b1) begin
      errors++;
      $display("FAIL collision_set_wins got %b exp 1", pend[2]);
    end
  endtask

  task automatic test_all_channels();
    mode = 8'hFF; sig = '0;
    for (int k = 0; k < 8; k++) tick();
    clr = '1; tick(); clr = '0;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL all_pre_clear got %b exp 0000", pend);
    end
    sig = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (rise !== 4'b1111) begin
      errors++;
      $display("FAIL all_rise got %b exp 1111", rise);
    end
    tick();
    checks++;
    if (pend !== 4'b1111) begin
      errors++;
      $display("FAIL all_pend got %b exp 1111", pend);
    end
    clr = 4'b0101; tick(); clr = '0;
    checks++;
    if ({pend, irq} !== 5'b1010_1) begin
      errors++;
      $display("FAIL all_partial_clear got %b exp 10101", {pend, irq});
    end
  endtask

  task automatic test_reset_mid();
    sig = '0;
    for (int k = 0; k < 8; k++) tick();
    clr = '1; tick(); clr = '0;
    sig = 4'b1000;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({level, rise, fall, pend, irq} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs got %b exp 0", {level, rise, fall, pend, irq});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if ({rise[3], pend} !== {(k == 5), 4'b0000}) begin
        errors++;
        $display("FAIL midreset_restart cyc %0d got rise3/pend %b exp %b", k,
                 {rise[3], pend}, {(k == 5), 4'b0000});
      end
    end
    tick();
    checks++;
    if (pend !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_pend got %b exp 1000", pend);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) sig[i] = ~sig[i];
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if ({level, rise, fall, pend, irq} !== {m_level, m_rise, m_fall, m_pend, m_irq}) begin
        errors++;
        $display("FAIL random cyc %0d got lvl %b r %b f %b p %b i %b exp lvl %b r %b f %b p %b i %b",
                 c, level, rise, fall, pend, irq, m_level, m_rise, m_fall, m_pend, m_irq);
      end
    end
    rst = 1'b0; clr = '0;
  endtask

  initial begin
    rst = 1'b1; sig = '0; mode = '0; clr = '0;
    test_reset();
    test_basic_rise();
    test_glitch();
    test_mode_pend();
    test_collision();
    test_all_channels();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
